// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, encodings and helpers for the snake game-state stage
// Purpose: cell codes, heading encodings, grid geometry and the reset head position.
// Ports: none (package).
package snake_pkg;

  localparam logic [1:0] CELL_NONE = 2'd0;
  localparam logic [1:0] CELL_HEAD = 2'd1;
  localparam logic [1:0] CELL_BODY = 2'd2;
  localparam logic [1:0] CELL_WALL = 2'd3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_e;

  localparam int GRID_W    = 40;
  localparam int GRID_H    = 30;
  localparam int CELL_SIZE = 16;

  localparam logic [5:0] RESET_HEAD_X = 6'd20;
  localparam logic [4:0] RESET_HEAD_Y = 5'd15;

  // Border ring of the playfield.
  function automatic logic is_wall(input logic [5:0] cx, input logic [4:0] cy);
    return (cx == 6'd0) || (cx == 6'(GRID_W - 1)) ||
           (cy == 5'd0) || (cy == 5'(GRID_H - 1));
  endfunction

  function automatic dir_e opposite(input dir_e d);
    dir_e r;
    case (d)
      DIR_UP:   r = DIR_DOWN;
      DIR_DOWN: r = DIR_UP;
      DIR_LEFT: r = DIR_RIGHT;
      default:  r = DIR_LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_cell_match.sv
// rtl/snake_cell_match.sv - compare one query cell against all valid snake segments
// Purpose: combinational head/body hit detection for a single grid cell.
// Ports:
//   qx, qy     query cell column/row
//   seg_x/y    segment storage, index 0 is the head
//   len        number of valid segments; body covers 1 <= i < len
//   head_hit   query equals segment 0
//   body_hit   query equals some segment i with 1 <= i < len
import snake_pkg::*;

module snake_cell_match #(
  parameter int MAX_LEN = 16
) (
  input  logic [5:0]                qx,
  input  logic [4:0]                qy,
  input  logic [MAX_LEN-1:0][5:0]   seg_x,
  input  logic [MAX_LEN-1:0][4:0]   seg_y,
  input  logic [6:0]                len,
  output logic                      head_hit,
  output logic                      body_hit
);

  always_comb begin
    head_hit = (seg_x[0] == qx) && (seg_y[0] == qy);
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((7'(i) < len) && (seg_x[i] == qx) && (seg_y[i] == qy)) begin
        body_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body_map.sv
// rtl/snake_body_map.sv - snake segment store, move/grow/kill logic and pixel classifier
// Purpose: holds snake segments on the 40x30 grid, advances them on move_tick and
//   answers each VGA pixel query with a registered NONE/HEAD/BODY/WALL code.
// Build option: SNAKE_SELF_HIT_EN enables death on self-collision; without it only
//   walls kill and the head may pass over the body.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   x_pos, y_pos      pixel being scanned by the VGA controller
//   move_tick         advance one cell
//   dir               requested heading (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT)
//   restart           reload the start configuration, only while dead
//   apple_x, apple_y  apple cell
//   snake             registered cell code for the previous pixel query
//   head_x, head_y    head cell
//   length            current segment count
//   eat               one-cycle pulse when a move lands on the apple
//   dead              high while in DEAD
import snake_pkg::*;

module snake_body_map #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       move_tick,
  input  logic [1:0] dir,
  input  logic       restart,
  input  logic [5:0] apple_x,
  input  logic [4:0] apple_y,
  output logic [1:0] snake,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [6:0] length,
  output logic       eat,
  output logic       dead
);

  state_e                   state_q, state_d;
  logic [MAX_LEN-1:0][5:0]  seg_x_q, seg_x_d;
  logic [MAX_LEN-1:0][4:0]  seg_y_q, seg_y_d;
  logic [6:0]               length_q, length_d;
  dir_e                     heading_q, heading_d;
  dir_e                     pending_q, pending_d;
  logic                     eat_q, eat_d;
  logic [1:0]               snake_q, snake_d;

  logic [5:0] next_x;
  logic [4:0] next_y;
  logic       wall_hit;
  logic       self_hit;
  logic       apple_hit;
  logic       do_shift;
  logic       do_restart;

  // Next head position from the pending heading. The head is never on a wall
  // while running, so the +/-1 cannot wrap.
  always_comb begin
    next_x = seg_x_q[0];
    next_y = seg_y_q[0];
    case (pending_q)
      DIR_UP:   next_y = seg_y_q[0] - 5'd1;
      DIR_DOWN: next_y = seg_y_q[0] + 5'd1;
      DIR_LEFT: next_x = seg_x_q[0] - 6'd1;
      default:  next_x = seg_x_q[0] + 6'd1;
    endcase
  end

  assign wall_hit  = is_wall(next_x, next_y);
  assign apple_hit = (next_x == apple_x) && (next_y == apple_y);

`ifdef SNAKE_SELF_HIT_EN
  logic unused_coll_head;

  // Passing length-1 limits the body compare to 1..length-2: the tail cell is
  // vacated by this same move, so running into it is legal.
  snake_cell_match #(.MAX_LEN(MAX_LEN)) u_coll_match (
    .qx       (next_x),
    .qy       (next_y),
    .seg_x    (seg_x_q),
    .seg_y    (seg_y_q),
    .len      (length_q - 7'd1),
    .head_hit (unused_coll_head),
    .body_hit (self_hit)
  );
`else
  assign self_hit = 1'b0;
`endif

  // State register together with the datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      length_q  <= 7'(INIT_LEN);
      heading_q <= DIR_RIGHT;
      pending_q <= DIR_RIGHT;
      eat_q     <= 1'b0;
      snake_q   <= CELL_NONE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= RESET_HEAD_X - 6'(i);
        seg_y_q[i] <= RESET_HEAD_Y;
      end
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      heading_q <= heading_d;
      pending_q <= pending_d;
      eat_q     <= eat_d;
      snake_q   <= snake_d;
      seg_x_q   <= seg_x_d;
      seg_y_q   <= seg_y_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (move_tick && (wall_hit || self_hit)) state_d = ST_DEAD;
      end
      default: begin
        if (restart) state_d = ST_RUN;
      end
    endcase
  end

  // State-decoded controls.
  always_comb begin
    dead       = (state_q == ST_DEAD);
    do_shift   = (state_q == ST_RUN) && move_tick && !wall_hit && !self_hit;
    do_restart = (state_q == ST_DEAD) && restart;
  end

  // Segment, length and heading updates.
  always_comb begin
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    length_d  = length_q;
    heading_d = heading_q;
    eat_d     = 1'b0;
    if (do_restart) begin
      length_d  = 7'(INIT_LEN);
      heading_d = DIR_RIGHT;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = RESET_HEAD_X - 6'(i);
        seg_y_d[i] = RESET_HEAD_Y;
      end
    end else if (do_shift) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
      seg_x_d[0] = next_x;
      seg_y_d[0] = next_y;
      heading_d  = pending_q;
      if (apple_hit) begin
        eat_d = 1'b1;
        if (length_q < 7'(MAX_LEN)) length_d = length_q + 7'd1;
      end
    end
  end

  // Reversal filter is checked against the heading this cycle leaves behind,
  // so a request made in a move cycle cannot undo the turn being applied.
  always_comb begin
    pending_d = pending_q;
    if (do_restart) begin
      pending_d = DIR_RIGHT;
    end else if (dir_e'(dir) != opposite(heading_d)) begin
      pending_d = dir_e'(dir);
    end
  end

  // Pixel classification.
  logic [5:0] pix_cx;
  logic [4:0] pix_cy;
  logic       pix_in_range;
  logic       pix_head;
  logic       pix_body;
  logic       unused_pix_lsbs;

  assign pix_cx          = x_pos[9:4];
  assign pix_cy          = y_pos[8:4];
  assign pix_in_range    = (x_pos < 10'(GRID_W * CELL_SIZE)) &&
                           (y_pos < 10'(GRID_H * CELL_SIZE));
  assign unused_pix_lsbs = ^{x_pos[3:0], y_pos[3:0]};

  snake_cell_match #(.MAX_LEN(MAX_LEN)) u_pix_match (
    .qx       (pix_cx),
    .qy       (pix_cy),
    .seg_x    (seg_x_q),
    .seg_y    (seg_y_q),
    .len      (length_q),
    .head_hit (pix_head),
    .body_hit (pix_body)
  );

  always_comb begin
    snake_d = CELL_NONE;
    if (pix_in_range) begin
      if (pix_head)                         snake_d = CELL_HEAD;
      else if (pix_body)                    snake_d = CELL_BODY;
      else if (is_wall(pix_cx, pix_cy))     snake_d = CELL_WALL;
    end
  end

  assign snake  = snake_q;
  assign head_x = seg_x_q[0];
  assign head_y = seg_y_q[0];
  assign length = length_q;
  assign eat    = eat_q;

endmodule

// File: tb/tb_snake_body_map.sv
// tb/tb_snake_body_map.sv - self-checking bench for snake_body_map
module tb_snake_body_map;

  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic       move_tick = 1'b0;
  logic [1:0] dir = 2'd3;
  logic       restart = 1'b0;
  logic [5:0] apple_x = '0;
  logic [4:0] apple_y = '0;
  logic [1:0] snake;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [6:0] length;
  logic       eat;
  logic       dead;

  always #5 clk = ~clk;

  snake_body_map #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .move_tick (move_tick),
    .dir       (dir),
    .restart   (restart),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .snake     (snake),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .eat       (eat),
    .dead      (dead)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: body as a queue of cells, head at the front.
  int qx[$];
  int qy[$];
  bit m_dead;
  bit m_eat;
  int m_head;
  int m_pend;

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit wall(input int cx, input int cy);
    return cx == 0 || cx == 39 || cy == 0 || cy == 29;
  endfunction

  function automatic void model_init();
    qx.delete();
    qy.delete();
    for (int i = 0; i < INIT_LEN; i++) begin
      qx.push_back(20 - i);
      qy.push_back(15);
    end
    m_dead = 0;
    m_eat  = 0;
    m_head = 3;
    m_pend = 3;
  endfunction

  function automatic int classify(input int px, input int py);
    int cx;
    int cy;
    if (px >= 640 || py >= 480) return 0;
    cx = px / 16;
    cy = py / 16;
    if (cx == qx[0] && cy == qy[0]) return 1;
    for (int i = 1; i < qx.size(); i++)
      if (cx == qx[i] && cy == qy[i]) return 2;
    if (wall(cx, cy)) return 3;
    return 0;
  endfunction

  function automatic bit self_hit(input int nx, input int ny);
`ifdef SNAKE_SELF_HIT_EN
    for (int i = 1; i <= qx.size() - 2; i++)
      if (nx == qx[i] && ny == qy[i]) return 1;
`endif
    return 0;
  endfunction

  task automatic compare_state();
    check("head_x", int'(head_x), qx[0]);
    check("head_y", int'(head_y), qy[0]);
    check("length", int'(length), qx.size());
    check("eat", int'(eat), int'(m_eat));
    check("dead", int'(dead), int'(m_dead));
  endtask

  // One clock: model follows the inputs present at the edge, then compare.
  task automatic cycle();
    int es;
    int nx;
    int ny;
    bit ate;
    es  = classify(int'(x_pos), int'(y_pos));
    ate = 0;
    if (restart && m_dead) begin
      model_init();
    end else begin
      if (move_tick && !m_dead) begin
        nx = qx[0];
        ny = qy[0];
        case (m_pend)
          0: ny = ny - 1;
          1: ny = ny + 1;
          2: nx = nx - 1;
          default: nx = nx + 1;
        endcase
        if (wall(nx, ny) || self_hit(nx, ny)) begin
          m_dead = 1;
        end else begin
          ate = (nx == int'(apple_x)) && (ny == int'(apple_y));
          qx.push_front(nx);
          qy.push_front(ny);
          if (!(ate && qx.size() - 1 < MAX_LEN)) begin
            void'(qx.pop_back());
            void'(qy.pop_back());
          end
          m_head = m_pend;
        end
      end
      if (int'(dir) != opp(m_head)) m_pend = int'(dir);
    end
    m_eat = ate;
    @(posedge clk);
    #1;
    check("snake", int'(snake), es);
    compare_state();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    move_tick = 1'b0;
    restart   = 1'b0;
    model_init();
    check("rst_snake", int'(snake), 0);
    check("rst_head_x", int'(head_x), 20);
    check("rst_head_y", int'(head_y), 15);
    check("rst_length", int'(length), INIT_LEN);
    check("rst_eat", int'(eat), 0);
    check("rst_dead", int'(dead), 0);
  endtask

  task automatic move(input int d);
    dir = 2'(d);
    cycle();
    move_tick = 1'b1;
    cycle();
    move_tick = 1'b0;
  endtask

  typedef struct {
    int x;
    int y;
    int exp;
  } pix_t;

  pix_t tbl[13];

  initial begin
    tbl[0]  = '{320, 240, 1};
    tbl[1]  = '{0,   0,   3};
    tbl[2]  = '{700, 100, 0};
    tbl[3]  = '{304, 240, 2};
    tbl[4]  = '{288, 250, 2};
    tbl[5]  = '{272, 240, 0};
    tbl[6]  = '{639, 100, 3};
    tbl[7]  = '{640, 100, 0};
    tbl[8]  = '{100, 479, 3};
    tbl[9]  = '{100, 480, 0};
    tbl[10] = '{16,  16,  0};
    tbl[11] = '{15,  200, 3};
    tbl[12] = '{335, 255, 1};

    dir = 2'd3;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      x_pos = 10'(tbl[i].x);
      y_pos = 10'(tbl[i].y);
      cycle();
      check("pix_tbl", int'(snake), tbl[i].exp);
    end

    // Three moves right.
    for (int i = 0; i < 3; i++) move(3);
    check("r3_head_x", int'(head_x), 23);
    check("r3_length", int'(length), 3);
    x_pos = 10'd336;
    y_pos = 10'd240;
    cycle();
    check("r3_seg2", int'(snake), 2);
    x_pos = 10'd320;
    cycle();
    check("r3_old_tail", int'(snake), 0);

    // Reversal request ignored.
    do_reset();
    move(2);
    check("rev_head_x", int'(head_x), 21);
    check("rev_head_y", int'(head_y), 15);

    // Eat and grow; tail holds for one move.
    do_reset();
    apple_x = 6'd21;
    apple_y = 5'd15;
    dir = 2'd3;
    cycle();
    move_tick = 1'b1;
    cycle();
    move_tick = 1'b0;
    check("eat_pulse", int'(eat), 1);
    check("eat_length", int'(length), 4);
    apple_x = 6'd0;
    apple_y = 5'd0;
    x_pos = 10'd288;
    y_pos = 10'd240;
    cycle();
    check("eat_pulse_end", int'(eat), 0);
    check("eat_tail_kept", int'(snake), 2);
    move(3);
    cycle();
    check("eat_tail_moved", int'(snake), 0);

    // Wall death, ignored ticks, restart winning over move_tick.
    do_reset();
    for (int i = 0; i < 18; i++) move(3);
    check("wall_alive", int'(dead), 0);
    check("wall_pre_x", int'(head_x), 38);
    move(3);
    check("wall_dead", int'(dead), 1);
    check("wall_head_x", int'(head_x), 38);
    move(3);
    move(0);
    check("dead_ignored_x", int'(head_x), 38);
    check("dead_ignored_y", int'(head_y), 15);
    restart   = 1'b1;
    move_tick = 1'b1;
    dir       = 2'd3;
    cycle();
    restart   = 1'b0;
    move_tick = 1'b0;
    check("restart_dead", int'(dead), 0);
    check("restart_head_x", int'(head_x), 20);
    check("restart_length", int'(length), INIT_LEN);

    // Reset while a move is requested discards the move.
    move(3);
    move(3);
    move_tick = 1'b1;
    do_reset();
    check("rst_mid_move_x", int'(head_x), 20);

    // Self-collision with length 5: UP, LEFT, DOWN.
    apple_x = 6'd21;
    apple_y = 5'd15;
    dir = 2'd3;
    cycle();
    move_tick = 1'b1;
    cycle();
    apple_x = 6'd22;
    cycle();
    move_tick = 1'b0;
    apple_x = 6'd0;
    apple_y = 5'd0;
    check("self_len5", int'(length), 5);
    move(0);
    move(2);
    move(1);
`ifdef SNAKE_SELF_HIT_EN
    check("self_dead", int'(dead), 1);
    check("self_head_y", int'(head_y), 14);
`else
    check("self_dead", int'(dead), 0);
    check("self_head_y", int'(head_y), 15);
`endif
    check("self_head_x", int'(head_x), 21);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int cx;
      int cy;
      if ($urandom_range(0, 3) == 0) dir = 2'($urandom_range(0, 3));
      move_tick = ($urandom_range(0, 2) == 0);
      restart   = m_dead && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        cx = qx[0];
        cy = qy[0];
        case (m_pend)
          0: cy = cy - 1;
          1: cy = cy + 1;
          2: cx = cx - 1;
          default: cx = cx + 1;
        endcase
        apple_x = 6'(cx);
        apple_y = 5'(cy);
      end else begin
        apple_x = 6'($urandom_range(0, 63));
        apple_y = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 1) == 0) begin
        cx = qx[0] + $urandom_range(0, 6) - 3;
        cy = qy[0] + $urandom_range(0, 6) - 3;
        if (cx < 0) cx = 0;
        if (cy < 0) cy = 0;
        x_pos = 10'(cx * 16 + $urandom_range(0, 15));
        y_pos = 10'(cy * 16 + $urandom_range(0, 15));
      end else begin
        x_pos = 10'($urandom_range(0, 799));
        y_pos = 10'($urandom_range(0, 524));
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_body_map.md
# snake_body_map

Game-state stage that sits directly upstream of the VGA controller. It holds the snake's segment coordinates on the 40x30 grid of 16x16-pixel cells. On each move tick it advances, grows or kills the snake. It answers every pixel query (x_pos, y_pos) with the 2-bit cell code the VGA controller paints as NONE/HEAD/BODY/WALL.

## Interface
- MAX_LEN, 16: segment capacity; legal range 4..64.
- INIT_LEN, 3: length after reset or restart; must be 2..MAX_LEN.
- clk  in  1  system clock, the same clock as the VGA controller.
- rst  in  1  asynchronous, active-high reset.
- x_pos  in  10  current pixel column from the VGA controller.
- y_pos  in  10  current pixel row from the VGA controller.
- move_tick  in  1  one-cycle pulse that advances the snake one cell.
- dir  in  2  requested heading: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
- restart  in  1  one-cycle pulse; honoured only in DEAD.
- apple_x  in  6  apple cell column.
- apple_y  in  5  apple cell row.
- snake  out  2  registered cell code for (x_pos, y_pos).
- head_x  out  6  head cell column.
- head_y  out  5  head cell row.
- length  out  7  current segment count.
- eat  out  1  one-cycle pulse when the head lands on the apple.
- dead  out  1  level, high while the state machine is in DEAD.

## Operation
- Cell codes: NONE=0, HEAD=1, BODY=2, WALL=3.
- Cell coordinates: cx=x_pos[9:4], cy=y_pos[9:4].
- Wall cells: cx==0, cx==39, cy==0 or cy==29.
- Classification priority: HEAD > BODY > WALL > NONE.
- Any pixel with x_pos>=640 or y_pos>=480 is classified NONE.
- Segment i is a body segment only when 1 <= i < length. Storage at i >= length is ignored.
- States: RUN and DEAD.
- Reset or restart loads length=INIT_LEN, heading RIGHT, seg0=(20,15) and segi=(20-i,15). The state becomes RUN.
- dir is sampled every cycle into a pending heading. A request opposite to the heading applied at the last move is discarded.
- On move_tick in RUN:
  - Compute the next head from the pending heading.
  - If the next head is a wall cell, or matches segi for 1 <= i <= length-2: go to DEAD. Segments are unchanged.
  - Otherwise shift: seg[i] <= seg[i-1], seg0 <= next head.
  - If the next head equals (apple_x, apple_y): pulse eat. length increments, saturating at MAX_LEN. An eat at MAX_LEN still pulses.
- move_tick in DEAD is ignored.
- If restart and move_tick arrive in the same cycle while in DEAD, restart wins.

## Timing
- snake has 1-cycle latency: it is registered from the x_pos/y_pos sampled on the previous edge.
- The move takes effect on the edge after the move_tick cycle. head_x, head_y, length, eat and dead all update on that same edge.
- Reset values:
  - snake=0
  - head_x=20
  - head_y=15
  - length=INIT_LEN
  - eat=0
  - dead=0
  - heading=RIGHT
- Reset asserted mid-move discards the move.
- The segment array may update while a frame is being scanned; tearing within a frame is accepted.

## Configuration
- SNAKE_SELF_HIT_EN defined: self-collision kills the snake as described above.
- SNAKE_SELF_HIT_EN undefined: only wall cells kill. The body-compare logic is removed, and the head may pass over the body.

## Structure
- snake_pkg holds:
  - the cell-code constants;
  - the direction encodings;
  - GRID_W=40, GRID_H=30 and the reset head coordinates.
- Sub-module snake_cell_match: combinational compare of one query cell against all valid segments. It returns head-hit and body-hit.
  - It is instantiated twice: once for pixel classification, once for the self-collision check.

## Test plan
- Reset, then query pixel (320,240) -> snake=HEAD one cycle later. Query (0,0) -> WALL. Query (700,100) -> NONE.
- From reset, 3 move_ticks with dir=RIGHT -> head=(23,15), length=3, segment2=(21,15).
- dir=LEFT issued while heading RIGHT, then move_tick -> head moves right to (21,15); the reversal is ignored.
- Apple at (21,15), then move_tick -> eat pulses for one cycle, length=4. The tail remains at (18,15) for one move.
- Drive RIGHT for 18 ticks from reset -> dead=1 on the 19th tick with head still at (38,15). Further move_ticks are ignored. restart -> reset configuration restored, dead=0.
- With SNAKE_SELF_HIT_EN and length 5, steer UP, LEFT, DOWN -> dead=1. With the macro undefined, the same sequence keeps dead=0.
